// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter that shares one ALU among NREQ requesters and routes
// each ALU result back to its issuer through an in-order tag FIFO.
module alu_req_arbiter #(
   parameter int NREQ       = 4,
   parameter int DATA_WIDTH = 8,
   parameter int TAG_DEPTH  = 4
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic [NREQ-1:0]            REQ,
   input  logic [4*NREQ-1:0]          REQ_OP,
   input  logic [2*NREQ-1:0]          REQ_MOVI,
   input  logic [DATA_WIDTH*NREQ-1:0] REQ_A,
   input  logic [DATA_WIDTH*NREQ-1:0] REQ_B,
   input  logic [DATA_WIDTH*NREQ-1:0] REQ_IMM,
   input  logic [DATA_WIDTH*NREQ-1:0] REQ_MEM,
   output logic [NREQ-1:0]            GNT,
   output logic                       ACT,
   output logic [3:0]                 OP,
   output logic [1:0]                 MOVI,
   output logic [DATA_WIDTH-1:0]      REG_A,
   output logic [DATA_WIDTH-1:0]      REG_B,
   output logic [DATA_WIDTH-1:0]      IMM,
   output logic [DATA_WIDTH-1:0]      MEM,
   input  logic                       ALU_RDY,
   input  logic [DATA_WIDTH-1:0]      EX_ALU,
   input  logic                       EX_ALU_VLD,
   output logic [DATA_WIDTH-1:0]      RES_DATA,
   output logic [NREQ-1:0]            RES_VLD,
   output logic                       ERR
);
   localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int PW  = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
   localparam int CW  = $clog2(TAG_DEPTH + 1);

   logic [3:0]            op_arr   [NREQ];
   logic [1:0]            movi_arr [NREQ];
   logic [DATA_WIDTH-1:0] a_arr    [NREQ];
   logic [DATA_WIDTH-1:0] b_arr    [NREQ];
   logic [DATA_WIDTH-1:0] imm_arr  [NREQ];
   logic [DATA_WIDTH-1:0] mem_arr  [NREQ];

   logic                  act_reg;
   logic [3:0]            op_reg;
   logic [1:0]            movi_reg;
   logic [DATA_WIDTH-1:0] a_reg, b_reg, imm_reg, mem_reg;
   logic [IDW-1:0]        rr_ptr_reg, hold_id_reg;
   logic [IDW-1:0]        tag_mem [TAG_DEPTH];
   logic [PW-1:0]         wr_ptr_reg, rd_ptr_reg;
   logic [CW-1:0]         fifo_cnt_reg;
   logic [NREQ-1:0]       res_vld_reg;
   logic [DATA_WIDTH-1:0] res_data_reg;
   logic                  err_reg;

   logic [2*NREQ-1:0]     req_dbl;
   logic [NREQ-1:0]       req_rot;
   logic [IDW-1:0]        offset;
   logic [IDW:0]          win_sum;
   logic [IDW-1:0]        winner;
   logic [IDW-1:0]        head_id;
   logic [NREQ-1:0]       head_onehot;
   logic                  slot_free, room, load, accept, pop;

   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_unpack
         assign op_arr[gi]      = REQ_OP[4*gi +: 4];
         assign movi_arr[gi]    = REQ_MOVI[2*gi +: 2];
         assign a_arr[gi]       = REQ_A[DATA_WIDTH*gi +: DATA_WIDTH];
         assign b_arr[gi]       = REQ_B[DATA_WIDTH*gi +: DATA_WIDTH];
         assign imm_arr[gi]     = REQ_IMM[DATA_WIDTH*gi +: DATA_WIDTH];
         assign mem_arr[gi]     = REQ_MEM[DATA_WIDTH*gi +: DATA_WIDTH];
         assign GNT[gi]         = load && (winner == IDW'(gi));
         assign head_onehot[gi] = (head_id == IDW'(gi));
      end
   endgenerate

   // Rotate so bit 0 is the requester just after rr_ptr; the lowest set bit wins.
   assign req_dbl = {REQ, REQ};
   assign req_rot = NREQ'(req_dbl >> ({1'b0, rr_ptr_reg} + (IDW+1)'(1)));

   always_comb begin
      offset = '0;
      for (int j = NREQ - 1; j >= 0; j--) begin
         if (req_rot[j]) offset = IDW'(j);
      end
      win_sum = {1'b0, rr_ptr_reg} + {1'b0, offset} + (IDW+1)'(1);
      if (win_sum >= (IDW+1)'(NREQ)) win_sum = win_sum - (IDW+1)'(NREQ);
      winner = win_sum[IDW-1:0];
   end

   // Credit only registered occupancy; a pop in this same cycle does not free room.
   assign slot_free = !act_reg || ALU_RDY;
   assign room      = ({1'b0, fifo_cnt_reg} + (CW+1)'(act_reg)) < (CW+1)'(TAG_DEPTH);
   assign load      = RST && slot_free && (|REQ) && room;
   assign accept    = act_reg && ALU_RDY;
   assign pop       = EX_ALU_VLD && (fifo_cnt_reg != '0);
   assign head_id   = tag_mem[rd_ptr_reg];

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         act_reg      <= 1'b0;
         op_reg       <= '0;
         movi_reg     <= '0;
         a_reg        <= '0;
         b_reg        <= '0;
         imm_reg      <= '0;
         mem_reg      <= '0;
         rr_ptr_reg   <= IDW'(NREQ - 1);
         hold_id_reg  <= '0;
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         fifo_cnt_reg <= '0;
         res_vld_reg  <= '0;
         res_data_reg <= '0;
         err_reg      <= 1'b0;
      end else begin
         if (load) begin
            act_reg     <= 1'b1;
            op_reg      <= op_arr[winner];
            movi_reg    <= movi_arr[winner];
            a_reg       <= a_arr[winner];
            b_reg       <= b_arr[winner];
            imm_reg     <= imm_arr[winner];
            mem_reg     <= mem_arr[winner];
            rr_ptr_reg  <= winner;
            hold_id_reg <= winner;
         end else if (slot_free) begin
            act_reg <= 1'b0;
         end

         if (accept) wr_ptr_reg <= wr_ptr_reg + PW'(1);
         if (pop)    rd_ptr_reg <= rd_ptr_reg + PW'(1);
         case ({accept, pop})
            2'b10:   fifo_cnt_reg <= fifo_cnt_reg + CW'(1);
            2'b01:   fifo_cnt_reg <= fifo_cnt_reg - CW'(1);
            default: fifo_cnt_reg <= fifo_cnt_reg;
         endcase

         res_vld_reg <= pop ? head_onehot : '0;
         if (pop) res_data_reg <= EX_ALU;
         if (EX_ALU_VLD && !pop) err_reg <= 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (accept) tag_mem[wr_ptr_reg] <= hold_id_reg;
   end

   assign ACT      = act_reg;
   assign OP       = op_reg;
   assign MOVI     = movi_reg;
   assign REG_A    = a_reg;
   assign REG_B    = b_reg;
   assign IMM      = imm_reg;
   assign MEM      = mem_reg;
   assign RES_VLD  = res_vld_reg;
   assign RES_DATA = res_data_reg;
   assign ERR      = err_reg;
endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed and randomized checks of alu_req_arbiter against a queue-based
// reference model of the arbitration and result-return rules.
module tb_alu_req_arbiter;
   localparam int NREQ = 4;
   localparam int DW   = 8;
   localparam int TD   = 4;

   logic                 CLK = 1'b0;
   logic                 RST;
   logic [NREQ-1:0]      REQ;
   logic [4*NREQ-1:0]    REQ_OP;
   logic [2*NREQ-1:0]    REQ_MOVI;
   logic [DW*NREQ-1:0]   REQ_A, REQ_B, REQ_IMM, REQ_MEM;
   logic [NREQ-1:0]      GNT;
   logic                 ACT;
   logic [3:0]           OP;
   logic [1:0]           MOVI;
   logic [DW-1:0]        REG_A, REG_B, IMM, MEM;
   logic                 ALU_RDY;
   logic [DW-1:0]        EX_ALU;
   logic                 EX_ALU_VLD;
   logic [DW-1:0]        RES_DATA;
   logic [NREQ-1:0]      RES_VLD;
   logic                 ERR;

   alu_req_arbiter #(.NREQ(NREQ), .DATA_WIDTH(DW), .TAG_DEPTH(TD)) dut (
      .CLK(CLK), .RST(RST), .REQ(REQ), .REQ_OP(REQ_OP), .REQ_MOVI(REQ_MOVI),
      .REQ_A(REQ_A), .REQ_B(REQ_B), .REQ_IMM(REQ_IMM), .REQ_MEM(REQ_MEM),
      .GNT(GNT), .ACT(ACT), .OP(OP), .MOVI(MOVI), .REG_A(REG_A), .REG_B(REG_B),
      .IMM(IMM), .MEM(MEM), .ALU_RDY(ALU_RDY), .EX_ALU(EX_ALU),
      .EX_ALU_VLD(EX_ALU_VLD), .RES_DATA(RES_DATA), .RES_VLD(RES_VLD), .ERR(ERR)
   );

   always #5 CLK = ~CLK;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state
   bit              m_act;
   logic [3:0]      m_op;
   logic [1:0]      m_movi;
   logic [DW-1:0]   m_a, m_b, m_imm, m_mem;
   int              m_rr;
   int              m_hold;
   int              tagq[$];
   logic [NREQ-1:0] m_res_vld;
   logic [DW-1:0]   m_res_data;
   bit              m_err;
   logic [NREQ-1:0] last_gnt;
   logic [NREQ-1:0] last_obs_gnt;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_act = 1'b0; m_op = '0; m_movi = '0;
      m_a = '0; m_b = '0; m_imm = '0; m_mem = '0;
      m_rr = NREQ - 1; m_hold = 0;
      tagq.delete();
      m_res_vld = '0; m_res_data = '0; m_err = 1'b0;
   endtask

   task automatic set_req_data(input int i);
      REQ_OP[4*i +: 4]     = 4'($urandom);
      REQ_MOVI[2*i +: 2]   = 2'($urandom);
      REQ_A[DW*i +: DW]    = DW'($urandom);
      REQ_B[DW*i +: DW]    = DW'($urandom);
      REQ_IMM[DW*i +: DW]  = DW'($urandom);
      REQ_MEM[DW*i +: DW]  = DW'($urandom);
   endtask

   function automatic int winner();
      for (int k = 1; k <= NREQ; k++) begin
         if (REQ[(m_rr + k) % NREQ]) return (m_rr + k) % NREQ;
      end
      return -1;
   endfunction

   function automatic bit load_ok();
      return (!m_act || ALU_RDY) && (REQ != '0) && ((tagq.size() + int'(m_act)) < TD);
   endfunction

   // One clock: called right after a negedge with inputs already applied.
   task automatic cycle();
      logic [NREQ-1:0] g;
      int  w;
      bit  ld, acc, pop;
      #2;
      ld = load_ok();
      w  = winner();
      g  = '0;
      if (ld) g[w] = 1'b1;
      chk("gnt", GNT, g);
      last_gnt = g;
      last_obs_gnt = GNT;
      @(posedge CLK);
      acc = m_act && ALU_RDY;
      pop = EX_ALU_VLD && (tagq.size() > 0);
      m_res_vld = '0;
      if (pop) begin
         m_res_vld[tagq[0]] = 1'b1;
         m_res_data = EX_ALU;
         void'(tagq.pop_front());
      end
      if (EX_ALU_VLD && !pop) m_err = 1'b1;
      if (acc) tagq.push_back(m_hold);
      if (ld) begin
         m_act  = 1'b1;
         m_op   = REQ_OP[4*w +: 4];
         m_movi = REQ_MOVI[2*w +: 2];
         m_a    = REQ_A[DW*w +: DW];
         m_b    = REQ_B[DW*w +: DW];
         m_imm  = REQ_IMM[DW*w +: DW];
         m_mem  = REQ_MEM[DW*w +: DW];
         m_rr   = w;
         m_hold = w;
      end else if (!m_act || ALU_RDY) begin
         m_act = 1'b0;
      end
      #1;
      chk("act", ACT, m_act);
      chk("op", OP, m_op);
      chk("movi", MOVI, m_movi);
      chk("reg_a", REG_A, m_a);
      chk("reg_b", REG_B, m_b);
      chk("imm", IMM, m_imm);
      chk("mem", MEM, m_mem);
      chk("res_vld", RES_VLD, m_res_vld);
      chk("res_data", RES_DATA, m_res_data);
      chk("err", ERR, m_err);
      $display("cyc t=%0t gnt=%b act=%b op=%h res_vld=%b res_data=%h err=%b tags=%0d",
               $time, last_obs_gnt, ACT, OP, RES_VLD, RES_DATA, ERR, tagq.size());
      @(negedge CLK);
   endtask

   task automatic do_reset();
      RST = 1'b0;
      #1;
      chk("rst_act", ACT, 1'b0);
      chk("rst_res_vld", RES_VLD, '0);
      chk("rst_err", ERR, 1'b0);
      chk("rst_gnt", GNT, '0);
      model_reset();
      @(negedge CLK);
      RST = 1'b1;
   endtask

   task automatic drain();
      int n;
      n = 0;
      REQ = '0;
      ALU_RDY = 1'b1;
      while ((tagq.size() > 0 || m_act) && n < 40) begin
         EX_ALU_VLD = (tagq.size() > 0);
         EX_ALU = DW'($urandom);
         cycle();
         n++;
      end
      EX_ALU_VLD = 1'b0;
      chk("drain_act", ACT, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [NREQ-1:0] exp_rr [5];
      int ngrants;
      exp_rr = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

      RST = 1'b0;
      REQ = '0; REQ_OP = '0; REQ_MOVI = '0;
      REQ_A = '0; REQ_B = '0; REQ_IMM = '0; REQ_MEM = '0;
      ALU_RDY = 1'b0; EX_ALU = '0; EX_ALU_VLD = 1'b0;
      for (int i = 0; i < NREQ; i++) set_req_data(i);
      model_reset();
      repeat (2) @(negedge CLK);
      chk("por_act", ACT, 1'b0);
      chk("por_res_data", RES_DATA, '0);
      chk("por_op", OP, 4'h0);
      chk("por_gnt", GNT, '0);
      RST = 1'b1;

      // Test 1: burst, then reset in the middle of it
      REQ = '1; ALU_RDY = 1'b1;
      for (int k = 0; k < 3; k++) begin
         EX_ALU_VLD = (tagq.size() > 0);
         EX_ALU = DW'($urandom);
         cycle();
      end
      #2;
      do_reset();

      // Test 2: round-robin with all requests held; first grant after reset goes to req0
      REQ = '1; ALU_RDY = 1'b1;
      for (int k = 0; k < 5; k++) begin
         EX_ALU_VLD = (tagq.size() > 0);
         EX_ALU = DW'($urandom);
         cycle();
         chk($sformatf("rr_gnt%0d", k), last_obs_gnt, exp_rr[k]);
         chk("rr_act", ACT, 1'b1);
      end

      // Test 3: MULT stall on requester 1
      drain();
      REQ = 4'b0010;
      REQ_OP[7:4] = 4'h2;
      REQ_A[15:8] = 8'h12;
      cycle();
      chk("mult_gnt", last_obs_gnt, 4'b0010);
      REQ = 4'b1101;
      REQ_OP[7:4] = 4'hF;
      REQ_A[15:8] = 8'hEE;
      ALU_RDY = 1'b0;
      for (int k = 0; k < 9; k++) begin
         cycle();
         chk("stall_gnt", last_obs_gnt, '0);
         chk("stall_op", OP, 4'h2);
         chk("stall_a", REG_A, 8'h12);
         chk("stall_act", ACT, 1'b1);
      end
      ALU_RDY = 1'b1;
      cycle();
      chk("stall_next", last_obs_gnt, 4'b0100);

      // Test 4: tag FIFO fills after exactly TAG_DEPTH accepts
      @(negedge CLK);
      #2;
      do_reset();
      REQ = '1; ALU_RDY = 1'b1; EX_ALU_VLD = 1'b0;
      ngrants = 0;
      for (int k = 0; k < 8; k++) begin
         cycle();
         ngrants += $countones(last_obs_gnt);
      end
      chk("full_grants", ngrants, TD);
      chk("full_gnt_zero", last_obs_gnt, '0);
      EX_ALU_VLD = 1'b1; EX_ALU = 8'h33;
      cycle();
      chk("full_pop_no_credit", last_obs_gnt, '0);
      EX_ALU_VLD = 1'b0;
      cycle();
      chk("full_regrant", last_obs_gnt, 4'b0001);

      // Test 5: result routing to the issuing requester
      @(negedge CLK);
      #2;
      do_reset();
      REQ = 4'b0100; ALU_RDY = 1'b1; EX_ALU_VLD = 1'b0;
      REQ_OP[11:8] = 4'h0; REQ_A[23:16] = 8'd3; REQ_B[23:16] = 8'd4;
      cycle();
      chk("route_gnt2", last_obs_gnt, 4'b0100);
      chk("route_a", REG_A, 8'd3);
      chk("route_b", REG_B, 8'd4);
      REQ = 4'b0001;
      cycle();
      chk("route_gnt0", last_obs_gnt, 4'b0001);
      REQ = '0; EX_ALU_VLD = 1'b1; EX_ALU = 8'd7;
      cycle();
      chk("route_res_vld", RES_VLD, 4'b0100);
      chk("route_res_data", RES_DATA, 8'd7);
      EX_ALU_VLD = 1'b0;
      cycle();
      chk("route_res_vld_pulse", RES_VLD, '0);

      // Randomized traffic
      for (int c = 0; c < 400; c++) begin
         ALU_RDY = ($urandom_range(0, 3) != 0);
         EX_ALU_VLD = (tagq.size() > 0) && ($urandom_range(0, 2) != 0);
         EX_ALU = DW'($urandom);
         cycle();
         for (int i = 0; i < NREQ; i++) begin
            if (last_gnt[i]) begin
               REQ[i] = ($urandom_range(0, 1) != 0);
               set_req_data(i);
            end else if (!REQ[i] && $urandom_range(0, 3) == 0) begin
               REQ[i] = 1'b1;
               set_req_data(i);
            end
         end
      end

      // Test 6: spurious result with empty tag FIFO
      drain();
      EX_ALU_VLD = 1'b1; EX_ALU = 8'h5A;
      cycle();
      chk("spur_err", ERR, 1'b1);
      chk("spur_res_vld", RES_VLD, '0);
      EX_ALU_VLD = 1'b0;
      repeat (3) cycle();
      chk("spur_err_sticky", ERR, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
